obi_wb_bridge: RTL and testbench

- Parametrised bridge between a core's OBI-style memory port (req/gnt/rvalid) and a classic Wishbone master port (cyc/stb/we/ack). It replaces the fixed gnt=1, stb=cyc wiring used in processorci_top wrappers.
- Adds:
  - a request queue, so the core can post up to FIFO_DEPTH requests;
  - byte-select pass-through;
  - write-response generation;
  - bus error and timeout reporting.
- One instance is used per memory port: instruction and data.

---
 rtl/obi_wb_bridge.sv | 169 ++++++++++++++++
 tb/tb_obi_wb_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge: OBI-style (req/gnt/rvalid) to classic Wishbone master bridge.
// Accepted requests are queued in a small FIFO. The head of the queue is
// presented on Wishbone until ack, err or timeout. One rvalid pulse is
// returned per request, in request order, and writes also get a response.
//   clk, rst_n                  clock, async active-low reset
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i   OBI request channel
//   rvalid_o/rdata_o/err_o      OBI response channel (no back-pressure)
//   wb_*                        Wishbone classic master
//   pending_o/busy_o            queued plus in-flight request count
module obi_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_i,
  output logic                             gnt_o,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic                             we_i,
  input  logic [DATA_WIDTH/8-1:0]          be_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic                             rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             err_o,
  output logic                             wb_cyc_o,
  output logic                             wb_stb_o,
  output logic                             wb_we_o,
  output logic [ADDR_WIDTH-1:0]            wb_addr_o,
  output logic [DATA_WIDTH/8-1:0]          wb_sel_o,
  output logic [DATA_WIDTH-1:0]            wb_data_o,
  input  logic [DATA_WIDTH-1:0]            wb_data_i,
  input  logic                             wb_ack_i,
  input  logic                             wb_err_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_o,
  output logic                             busy_o
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BW-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // ---------------- request queue ----------------
  req_t            mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop;

  state_t          state_q;
  logic [TW-1:0]   tmo_cnt_q;
  logic            wb_cyc_q, wb_we_q, rvalid_q, err_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [BW-1:0]   wb_sel_q;
  logic [DATA_WIDTH-1:0] wb_data_q, rdata_q;
  logic            tmo_hit, term, term_err;
  req_t            head;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // Gating with rst_n keeps the grant low while reset is held.
  assign gnt_o = rst_n & ~full;
  assign push  = req_i & gnt_o;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
  end

  // ---------------- bus FSM ----------------
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);
  assign term     = wb_ack_i | wb_err_i | tmo_hit;
  // Error wins over ack; a timeout only counts when nothing answered.
  assign term_err = wb_err_i | ~wb_ack_i;
  // Head leaves the queue only when its Wishbone cycle terminates.
  assign pop      = (state_q == BUS) & term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      wb_cyc_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_sel_q  <= '0;
      wb_data_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          wb_cyc_q  <= 1'b1;
          wb_we_q   <= head.we;
          wb_addr_q <= head.addr;
          wb_sel_q  <= head.be;
          wb_data_q <= head.wdata;
          tmo_cnt_q <= '0;
          state_q   <= BUS;
        end
        BUS: begin
          tmo_cnt_q <= tmo_cnt_q + TW'(1);
          if (term) begin
            wb_cyc_q <= 1'b0;
            rvalid_q <= 1'b1;
            err_q    <= term_err;
            rdata_q  <= (!wb_we_q && !term_err) ? wb_data_i : '0;
            state_q  <= RESP;
          end
        end
        default: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign wb_cyc_o  = wb_cyc_q;
  assign wb_stb_o  = wb_cyc_q;
  assign wb_we_o   = wb_we_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_sel_o  = wb_sel_q;
  assign wb_data_o = wb_data_q;
  assign rvalid_o  = rvalid_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign pending_o = count_q;
  assign busy_o    = (count_q != '0);
endmodule

// File: tb/tb_obi_wb_bridge.sv
// Directed bench for obi_wb_bridge: a vector table of single transactions,
// plus hand-written sequences for back-pressure, timeout and reset.
module tb_obi_wb_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, gnt, rvalid, err, cyc, stb, wbwe, ack, berr, busy;
  logic [31:0] addr, wdata, rdata, wbaddr, wbdo, wbdi;
  logic [3:0]  be, sel;
  logic [1:0]  pend;
  // second instance: timeout disabled, Wishbone never answers
  logic        req0, gnt0, rvalid0, err0, cyc0, stb0, wbwe0, busy0;
  logic        ack0 = 1'b0, berr0 = 1'b0;
  logic [31:0] rdata0, wbaddr0, wbdo0;
  logic [3:0]  sel0;
  logic [1:0]  pend0;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(wbwe), .wb_addr_o(wbaddr), .wb_sel_o(sel),
    .wb_data_o(wbdo), .wb_data_i(wbdi), .wb_ack_i(ack), .wb_err_i(berr),
    .pending_o(pend), .busy_o(busy));

  obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(2), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .gnt_o(gnt0), .addr_i(addr), .we_i(1'b0),
    .be_i(4'hF), .wdata_i(wdata), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0),
    .wb_cyc_o(cyc0), .wb_stb_o(stb0), .wb_we_o(wbwe0), .wb_addr_o(wbaddr0), .wb_sel_o(sel0),
    .wb_data_o(wbdo0), .wb_data_i(wbdi), .wb_ack_i(ack0), .wb_err_i(berr0),
    .pending_o(pend0), .busy_o(busy0));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          wait_n;
    logic        ack, berr;
    logic [31:0] bus_rd;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Accept at cycle N, check cyc at N+2, answer after wait_n cycles, check response.
  task automatic do_txn(input vec_t v);
    req = 1'b1; we = v.we; addr = v.addr; be = v.be; wdata = v.wdata;
    chk("gnt_idle", gnt, 1);
    @(negedge clk);
    req = 1'b0;
    chk("cyc_n1", cyc, 0);
    @(negedge clk);
    chk("cyc_n2", cyc, 1);
    chk("stb", stb, 1);
    chk("wb_we", wbwe, v.we);
    chk("wb_sel", sel, v.be);
    chk("wb_addr", wbaddr, v.addr);
    chk("wb_data", wbdo, v.wdata);
    for (int i = 0; i < v.wait_n; i++) @(negedge clk);
    chk("cyc_hold", cyc, 1);
    chk("addr_hold", wbaddr, v.addr);
    ack = v.ack; berr = v.berr; wbdi = v.bus_rd;
    @(negedge clk);
    ack = 1'b0; berr = 1'b0;
    chk("rvalid", rvalid, 1);
    chk("err", err, v.exp_err);
    chk("rdata", rdata, v.exp_rdata);
    chk("cyc_drop", cyc, 0);
    @(negedge clk);
    chk("rvalid_pulse", rvalid, 0);
  endtask

  // Wait (bounded) for the next Wishbone cycle, ack it with data d.
  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] d);
    int n = 0;
    while (!cyc && n < 20) begin @(negedge clk); n++; end
    chk("serve_cyc", cyc, 1);
    chk("serve_addr", wbaddr, exp_addr);
    ack = 1'b1; wbdi = d;
    @(negedge clk);
    ack = 1'b0;
    chk("serve_rvalid", rvalid, 1);
    chk("serve_rdata", rdata, d);
    chk("serve_err", err, 0);
  endtask

  initial begin
    int cnt, viol;
    vecs[0] = '{1'b0, 32'h0000_0010, 4'hF,    32'h0,         0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678, 3, 1'b1, 1'b0, 32'hFFFF_0000, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0024, 4'b1100, 32'h0,         1, 1'b0, 1'b1, 32'h5555_AAAA, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0028, 4'hF,    32'h0,         0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h0000_002C, 4'b1000, 32'hA5A5_0001, 2, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0030, 4'hF,    32'h0,         7, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};

    rst_n = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; be = 4'hF; wdata = '0;
    ack = 1'b0; berr = 1'b0; wbdi = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_pend", pend, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // back-pressure: two grants then gnt low, ack frees one slot
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h100;
    chk("bp_gnt0", gnt, 1);
    @(negedge clk);
    chk("bp_gnt1", gnt, 1);
    chk("bp_pend1", pend, 1);
    addr = 32'h104;
    @(negedge clk);
    chk("bp_gnt_full", gnt, 0);
    chk("bp_pend2", pend, 2);
    chk("bp_busy", busy, 1);
    chk("bp_addrA", wbaddr, 32'h100);
    addr = 32'h108;
    @(negedge clk);
    chk("bp_gnt_held", gnt, 0);
    ack = 1'b1; wbdi = 32'hA0;
    @(negedge clk);
    ack = 1'b0;
    chk("bp_rvalidA", rvalid, 1);
    chk("bp_rdataA", rdata, 32'hA0);
    chk("bp_gnt_back", gnt, 1);
    chk("bp_pend_pop", pend, 1);
    @(negedge clk);
    req = 1'b0;
    chk("bp_pend_refill", pend, 2);
    serve(32'h104, 32'hB0);
    serve(32'h108, 32'hC0);
    @(negedge clk);
    chk("bp_pend_empty", pend, 0);

    // timeout after exactly 8 bus cycles, next request proceeds
    req = 1'b1; addr = 32'h200;
    @(negedge clk);
    addr = 32'h204;
    @(negedge clk);
    req = 1'b0;
    cnt = 0;
    while (!cyc && cnt < 20) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (cyc && cnt < 50) begin cnt++; @(negedge clk); end
    chk("tmo_cycles", cnt, 8);
    chk("tmo_rvalid", rvalid, 1);
    chk("tmo_err", err, 1);
    chk("tmo_rdata", rdata, 0);
    serve(32'h204, 32'hD0);

    // timeout disabled: cycle stays open, no response
    req0 = 1'b1; addr = 32'h300;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    viol = 0;
    repeat (1000) begin
      if (!cyc0 || rvalid0) viol++;
      @(negedge clk);
    end
    chk("notmo_viol", viol, 0);
    chk("notmo_cyc", cyc0, 1);

    // reset mid-bus with two requests pending
    @(negedge clk);
    req = 1'b1; addr = 32'h400;
    @(negedge clk);
    addr = 32'h404;
    @(negedge clk);
    req = 1'b0;
    chk("mr_cyc_pre", cyc, 1);
    chk("mr_pend_pre", pend, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_cyc_async", cyc, 0);
    chk("mr_pend_async", pend, 0);
    chk("mr_busy_async", busy, 0);
    chk("mr_gnt_async", gnt, 0);
    chk("mr_cyc0_async", cyc0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (rvalid || cyc) viol++;
    end
    chk("mr_no_resp", viol, 0);
    do_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
